// File: rtl/opfetch_stage.sv
// Operand-fetch stage: register read, writeback bypass, scoreboard hazard stall and a valid/ready output slot.
// Optional stall counter output enabled by defining OPFETCH_STALL_CNT_EN.
module opfetch_stage #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CTRL_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs,
  input  logic [ADDR_WIDTH-1:0] in_rt,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_wen,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  output logic [ADDR_WIDTH-1:0] rf_r1_addr,
  output logic [ADDR_WIDTH-1:0] rf_r2_addr,
  input  logic [DATA_WIDTH-1:0] rf_r1_data,
  input  logic [DATA_WIDTH-1:0] rf_r2_data,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_a,
  output logic [DATA_WIDTH-1:0] out_b,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_wen,
  output logic [CTRL_WIDTH-1:0] out_ctrl
`ifdef OPFETCH_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int unsigned NREGS = 1 << ADDR_WIDTH;

  logic [NREGS-1:0]      busy;
  logic [NREGS-1:0]      busy_nxt;
  logic [NREGS-1:0]      clr;
  logic [NREGS-1:0]      flush_clr;
  logic [NREGS-1:0]      set_vec;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic                  rs_haz;
  logic                  rt_haz;
  logic                  waw;
  logic                  hazard;
  logic                  slot_free;
  logic                  accept;

  assign rf_r1_addr = in_rs;
  assign rf_r2_addr = in_rt;

  // Register 0 reads as zero; same-cycle writeback beats the register file.
  assign op_a = (in_rs == '0) ? '0 :
                (wb_valid && wb_addr == in_rs) ? wb_data : rf_r1_data;
  assign op_b = (in_rt == '0) ? '0 :
                (wb_valid && wb_addr == in_rt) ? wb_data : rf_r2_data;

  always_comb begin
    clr       = '0;
    flush_clr = '0;
    set_vec   = '0;
    if (wb_valid && wb_addr != '0)
      clr[wb_addr] = 1'b1;
    if (flush && out_valid && out_wen && out_rd != '0)
      flush_clr[out_rd] = 1'b1;
    if (accept && in_wen && in_rd != '0)
      set_vec[in_rd] = 1'b1;
  end

  assign rs_haz    = (in_rs != '0) && busy[in_rs] && !clr[in_rs];
  assign rt_haz    = (in_rt != '0) && busy[in_rt] && !clr[in_rt];
  assign waw       = in_wen && (in_rd != '0) && busy[in_rd] && !clr[in_rd];
  assign hazard    = rs_haz | rt_haz | waw;
  assign slot_free = !out_valid || out_ready;
  assign in_ready  = slot_free && !hazard && !flush;
  assign accept    = in_valid && in_ready;

  // A new pending write wins over a same-cycle clear of the same register.
  assign busy_nxt = (busy & ~clr & ~flush_clr) | set_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  // Output slot: data fields only change on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_rd    <= '0;
      out_wen   <= 1'b0;
      out_ctrl  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_a     <= op_a;
      out_b     <= op_b;
      out_rd    <= in_rd;
      out_wen   <= in_wen;
      out_ctrl  <= in_ctrl;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef OPFETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= 16'd0;
    else if (in_valid && hazard && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_opfetch_stage.sv
// Directed, table-driven bench for opfetch_stage; covers stall counter when OPFETCH_STALL_CNT_EN is defined.
module tb_opfetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_wen;
  logic [7:0]  in_ctrl;
  logic [4:0]  rf_r1_addr, rf_r2_addr;
  logic [15:0] rf_r1_data, rf_r2_data;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_a, out_b;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [7:0]  out_ctrl;
`ifdef OPFETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  opfetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .in_ctrl    (in_ctrl),
    .rf_r1_addr (rf_r1_addr),
    .rf_r2_addr (rf_r2_addr),
    .rf_r1_data (rf_r1_data),
    .rf_r2_data (rf_r2_data),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_rd     (out_rd),
    .out_wen    (out_wen),
    .out_ctrl   (out_ctrl)
`ifdef OPFETCH_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  typedef struct {
    logic        v;
    logic [4:0]  rs, rt, rd;
    logic        wen;
    logic [7:0]  ctrl;
    logic [15:0] r1, r2;
    logic        wbv;
    logic [4:0]  wba;
    logic [15:0] wbd;
    logic        ordy;
    logic        e_ird;
    logic        e_ov;
    logic [15:0] e_a, e_b;
    logic [4:0]  e_rd;
    logic        e_wen;
    logic [7:0]  e_ctrl;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic wen, input logic [7:0] ctrl,
                       input logic [15:0] r1, input logic [15:0] r2,
                       input logic wbv, input logic [4:0] wba, input logic [15:0] wbd,
                       input logic fl, input logic ordy);
    in_valid = v; in_rs = rs; in_rt = rt; in_rd = rd; in_wen = wen; in_ctrl = ctrl;
    rf_r1_data = r1; rf_r2_data = r2;
    wb_valid = wbv; wb_addr = wba; wb_data = wbd;
    flush = fl; out_ready = ordy;
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [15:0] a,
                         input logic [15:0] b, input logic [4:0] rd, input logic wen,
                         input logic [7:0] ctrl);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".out_a"},     32'(out_a),     32'(a));
    chk({tag, ".out_b"},     32'(out_b),     32'(b));
    chk({tag, ".out_rd"},    32'(out_rd),    32'(rd));
    chk({tag, ".out_wen"},   32'(out_wen),   32'(wen));
    chk({tag, ".out_ctrl"},  32'(out_ctrl),  32'(ctrl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           v   rs    rt    rd    wen  ctrl   r1        r2        wbv  wba    wbd       ordy  ird  ov   a         b         rd    wen  ctrl
    vecs[0]  = '{1, 5'd3, 5'd4, 5'd1, 0, 8'h11, 16'h1111, 16'h2222, 0, 5'd0, 16'h0000, 1, 1, 1, 16'h1111, 16'h2222, 5'd1, 0, 8'h11};
    vecs[1]  = '{1, 5'd0, 5'd0, 5'd5, 1, 8'h22, 16'hDEAD, 16'hDEAD, 0, 5'd0, 16'h0000, 1, 1, 1, 16'h0000, 16'h0000, 5'd5, 1, 8'h22};
    vecs[2]  = '{1, 5'd5, 5'd0, 5'd6, 0, 8'h33, 16'hAAAA, 16'h0000, 0, 5'd0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 5'd5, 1, 8'h22};
    vecs[3]  = '{1, 5'd5, 5'd0, 5'd6, 0, 8'h33, 16'hAAAA, 16'h0000, 1, 5'd5, 16'hBEEF, 1, 1, 1, 16'hBEEF, 16'h0000, 5'd6, 0, 8'h33};
    vecs[4]  = '{1, 5'd1, 5'd2, 5'd7, 1, 8'h44, 16'h0101, 16'h0202, 0, 5'd0, 16'h0000, 1, 1, 1, 16'h0101, 16'h0202, 5'd7, 1, 8'h44};
    vecs[5]  = '{1, 5'd0, 5'd0, 5'd7, 1, 8'h55, 16'h0000, 16'h0000, 0, 5'd0, 16'h0000, 1, 0, 0, 16'h0101, 16'h0202, 5'd7, 1, 8'h44};
    vecs[6]  = '{1, 5'd0, 5'd0, 5'd7, 1, 8'h55, 16'h0000, 16'h0000, 0, 5'd0, 16'h0000, 1, 0, 0, 16'h0101, 16'h0202, 5'd7, 1, 8'h44};
    vecs[7]  = '{1, 5'd0, 5'd0, 5'd7, 1, 8'h55, 16'h0000, 16'h0000, 1, 5'd7, 16'h1234, 1, 1, 1, 16'h0000, 16'h0000, 5'd7, 1, 8'h55};
    vecs[8]  = '{1, 5'd7, 5'd0, 5'd0, 0, 8'h66, 16'h9999, 16'h0000, 0, 5'd0, 16'h0000, 1, 0, 0, 16'h0000, 16'h0000, 5'd7, 1, 8'h55};
    vecs[9]  = '{1, 5'd7, 5'd0, 5'd0, 0, 8'h66, 16'h9999, 16'h0000, 1, 5'd7, 16'h7777, 1, 1, 1, 16'h7777, 16'h0000, 5'd0, 0, 8'h66};
    vecs[10] = '{1, 5'd0, 5'd0, 5'd0, 1, 8'h77, 16'h5555, 16'h6666, 1, 5'd0, 16'hFFFF, 1, 1, 1, 16'h0000, 16'h0000, 5'd0, 1, 8'h77};
    vecs[11] = '{1, 5'd2, 5'd3, 5'd8, 0, 8'h88, 16'h2020, 16'h3030, 1, 5'd2, 16'h4242, 1, 1, 1, 16'h4242, 16'h3030, 5'd8, 0, 8'h88};
    vecs[12] = '{0, 5'd0, 5'd0, 5'd0, 0, 8'h00, 16'h0000, 16'h0000, 0, 5'd0, 16'h0000, 1, 1, 0, 16'h4242, 16'h3030, 5'd8, 0, 8'h88};

    rst = 1'b1;
    drive(0, 5'd0, 5'd0, 5'd0, 0, 8'h00, 16'h0, 16'h0, 0, 5'd0, 16'h0, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 16'h0, 16'h0, 5'd0, 0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].wen, vecs[i].ctrl,
            vecs[i].r1, vecs[i].r2, vecs[i].wbv, vecs[i].wba, vecs[i].wbd, 0, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_ird));
      chk($sformatf("v%0d.rf_r1_addr", i), 32'(rf_r1_addr), 32'(vecs[i].rs));
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", i), vecs[i].e_ov, vecs[i].e_a, vecs[i].e_b,
              vecs[i].e_rd, vecs[i].e_wen, vecs[i].e_ctrl);
    end

    // Backpressure: held slot must stay stable and block new issues.
    @(negedge clk);
    drive(1, 5'd3, 5'd4, 5'd10, 1, 8'hA1, 16'h0001, 16'h0002, 0, 5'd0, 16'h0, 0, 0);
    @(posedge clk); #1;
    chk_out("bp_load", 1, 16'h0001, 16'h0002, 5'd10, 1, 8'hA1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1, 5'd0, 5'd0, 5'd11, 0, 8'hB2, 16'h0, 16'h0, 0, 5'd0, 16'h0, 0, 0);
      #1;
      chk($sformatf("bp_hold%0d.in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk_out($sformatf("bp_hold%0d", c), 1, 16'h0001, 16'h0002, 5'd10, 1, 8'hA1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk_out("bp_release", 1, 16'h0000, 16'h0000, 5'd11, 0, 8'hB2);
    @(negedge clk);
    drive(0, 5'd0, 5'd0, 5'd0, 0, 8'h00, 16'h0, 16'h0, 1, 5'd10, 16'h0, 0, 1);
    @(posedge clk); #1;
    chk("bp_drain.out_valid", 32'(out_valid), 32'd0);

    // Flush kills the held write and frees its scoreboard entry.
    @(negedge clk);
    drive(1, 5'd0, 5'd0, 5'd9, 1, 8'hC3, 16'h0, 16'h0, 0, 5'd0, 16'h0, 0, 0);
    @(posedge clk); #1;
    chk("fl_load.out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    drive(1, 5'd9, 5'd0, 5'd0, 0, 8'hC4, 16'h9090, 16'h0, 0, 5'd0, 16'h0, 1, 0);
    #1;
    chk("fl_cycle.in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("fl_cycle.out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    drive(1, 5'd9, 5'd0, 5'd0, 0, 8'hC4, 16'h9090, 16'h0, 0, 5'd0, 16'h0, 0, 1);
    #1;
    chk("fl_after.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk_out("fl_after", 1, 16'h9090, 16'h0000, 5'd0, 0, 8'hC4);
    @(negedge clk);
    drive(0, 5'd0, 5'd0, 5'd0, 0, 8'h00, 16'h0, 16'h0, 0, 5'd0, 16'h0, 0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    chk_out("fl_idle", 0, 16'h9090, 16'h0000, 5'd0, 0, 8'hC4);

    // Asynchronous reset mid-operation drops the slot and the scoreboard.
    @(negedge clk);
    drive(1, 5'd0, 5'd0, 5'd12, 1, 8'hD5, 16'h0, 16'h0, 0, 5'd0, 16'h0, 0, 0);
    @(posedge clk); #1;
    chk("rst_mid.load", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_out("rst_mid", 0, 16'h0, 16'h0, 5'd0, 0, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 5'd12, 5'd0, 5'd0, 0, 8'hD6, 16'h0C0C, 16'h0, 0, 5'd0, 16'h0, 0, 1);
    #1;
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk_out("rst_mid_after", 1, 16'h0C0C, 16'h0000, 5'd0, 0, 8'hD6);

    // Four-cycle RAW stall on register 13.
    @(negedge clk);
    drive(1, 5'd0, 5'd0, 5'd13, 1, 8'hE7, 16'h0, 16'h0, 0, 5'd0, 16'h0, 0, 1);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1, 5'd13, 5'd0, 5'd0, 0, 8'hE8, 16'h0, 16'h0, 0, 5'd0, 16'h0, 0, 1);
      #1;
      chk($sformatf("raw4_%0d.in_ready", c), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
`ifdef OPFETCH_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'd4);
`endif
    @(negedge clk);
    drive(0, 5'd0, 5'd0, 5'd0, 0, 8'h00, 16'h0, 16'h0, 1, 5'd13, 16'h0, 0, 1);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
